// File: rtl/count_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : count_display_driver
// Purpose : Sequential binary-to-BCD conversion of the seconds count feeding a
//           4-digit multiplexed active-low seven-segment display.
// Revision: 1.0 - initial release
// ============================================================================
module count_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [15:0] Count,
   input  logic        StopCounter,
   output logic [15:0] BcdOut,
   output logic        Overflow,
   output logic        Busy,
   output logic        FinalShown,
   output logic [3:0]  Anode,
   output logic [6:0]  Seg
);

   localparam int                 c_REF_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_LOAD    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   bin_q, bin_d;
   logic [19:0]   scratch_q, scratch_d;
   logic [4:0]    iter_q, iter_d;
   logic [15:0]   last_q, last_d;
   logic          valid_q, valid_d;
   logic          stop_q, stop_d;
   logic [15:0]   bcd_q, bcd_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic          final_q, final_d;
   logic [19:0]   w_adj;

   // Add-3 correction on every scratch digit before each shift
   for (genvar k = 0; k < 5; k++) begin : g_adj
      assign w_adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                             : scratch_q[4*k +: 4];
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      iter_d    = iter_q;
      last_d    = last_q;
      valid_d   = valid_q;
      stop_d    = stop_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      final_d   = final_q;
      case (state_q)
         S_IDLE: begin
            if (!valid_q || (Count != last_q)) begin
               bin_d     = Count;
               last_d    = Count;
               stop_d    = StopCounter;
               scratch_d = '0;
               iter_d    = '0;
               busy_d    = 1'b1;
               state_d   = S_CONVERT;
            end
         end
         S_CONVERT: begin
            scratch_d = {w_adj[18:0], bin_q[15]};
            bin_d     = {bin_q[14:0], 1'b0};
            iter_d    = iter_q + 5'd1;
            if (iter_q == 5'd15) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (scratch_q[19:16] != 4'd0) begin
               bcd_d = 16'h9999;
               ovf_d = 1'b1;
            end else begin
               bcd_d = scratch_q[15:0];
               ovf_d = 1'b0;
            end
            valid_d = 1'b1;
            busy_d  = 1'b0;
            if (stop_q) final_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         iter_q    <= '0;
         last_q    <= '0;
         valid_q   <= 1'b0;
         stop_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         final_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         iter_q    <= iter_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
         stop_q    <= stop_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         final_q   <= final_d;
      end
   end

   logic [c_REF_W-1:0] ref_q;
   logic [1:0]         sel_q;
   logic [3:0]         anode_q;
   logic [6:0]         seg_q;
   logic [3:0]         w_digit;
   logic               w_blank;
   logic [6:0]         w_seg;

   always_comb begin
      w_digit = bcd_q[3:0];
      w_blank = 1'b0;
      case (sel_q)
         2'd0: w_digit = bcd_q[3:0];
         2'd1: begin w_digit = bcd_q[7:4];   w_blank = (bcd_q[15:4]  == 12'd0); end
         2'd2: begin w_digit = bcd_q[11:8];  w_blank = (bcd_q[15:8]  == 8'd0);  end
         default: begin w_digit = bcd_q[15:12]; w_blank = (bcd_q[15:12] == 4'd0); end
      endcase
      case (w_digit)
         4'd0: w_seg = 7'b1000000;
         4'd1: w_seg = 7'b1111001;
         4'd2: w_seg = 7'b0100100;
         4'd3: w_seg = 7'b0110000;
         4'd4: w_seg = 7'b0011001;
         4'd5: w_seg = 7'b0010010;
         4'd6: w_seg = 7'b0000010;
         4'd7: w_seg = 7'b1111000;
         4'd8: w_seg = 7'b0000000;
         4'd9: w_seg = 7'b0010000;
         default: w_seg = 7'b1111111;
      endcase
      if (BLANK_LZ && w_blank) w_seg = 7'b1111111;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         ref_q   <= '0;
         sel_q   <= 2'd0;
         anode_q <= 4'b1111;
         seg_q   <= 7'b1111111;
      end else begin
         if (ref_q == c_REF_MAX) begin
            ref_q <= '0;
            sel_q <= sel_q + 2'd1;
         end else begin
            ref_q <= ref_q + 1'b1;
         end
         anode_q <= ~(4'b0001 << sel_q);
         seg_q   <= w_seg;
      end
   end

   assign BcdOut     = bcd_q;
   assign Overflow   = ovf_q;
   assign Busy       = busy_q;
   assign FinalShown = final_q;
   assign Anode      = anode_q;
   assign Seg        = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_count_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_display_driver
// Purpose : Directed plus randomized bench against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_count_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        Reset;
   logic [15:0] Count;
   logic        StopCounter;
   logic [15:0] BcdOut;
   logic        Overflow, Busy, FinalShown;
   logic [3:0]  Anode;
   logic [6:0]  Seg;

   int vectors   = 0;
   int miscompares = 0;

   count_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .Reset(Reset), .Count(Count), .StopCounter(StopCounter),
      .BcdOut(BcdOut), .Overflow(Overflow), .Busy(Busy), .FinalShown(FinalShown),
      .Anode(Anode), .Seg(Seg)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int pow10 [0:3] = '{1, 10, 100, 1000};

   // Model: displayed value as an integer, conversion as a countdown to the load edge
   int          m_bcd, m_val, m_left, m_edge;
   logic [15:0] m_last;
   logic        m_valid, m_stop, m_ovf, m_busy, m_final;
   logic [3:0]  m_anode;
   logic [6:0]  m_seg;

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] seg_of(int v, int k);
      if (k > 0 && v < pow10[k]) return 7'b1111111;
      return seg_tab[(v / pow10[k]) % 10];
   endfunction

   task automatic model_edge();
      int k;
      if (Reset) begin
         m_valid = 1'b0; m_last = '0; m_left = 0; m_bcd = 0; m_ovf = 1'b0;
         m_busy = 1'b0; m_final = 1'b0; m_edge = 0; m_stop = 1'b0; m_val = 0;
         m_anode = 4'b1111; m_seg = 7'b1111111;
      end else begin
         k       = (m_edge / DIV) % 4;
         m_anode = ~(4'b0001 << k);
         m_seg   = seg_of(m_bcd, k);
         m_edge++;
         if (m_left == 0) begin
            if (!m_valid || Count != m_last) begin
               m_val  = int'(Count);
               m_last = Count;
               m_stop = StopCounter;
               m_left = 17;
               m_busy = 1'b1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_ovf   = (m_val > 9999);
               m_bcd   = m_ovf ? 9999 : m_val;
               m_valid = 1'b1;
               m_busy  = 1'b0;
               if (m_stop) m_final = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      vectors++;
      assert (BcdOut === to_bcd(m_bcd)) else begin
         miscompares++; $error("FAIL bcd t=%0t got %h exp %h", $time, BcdOut, to_bcd(m_bcd));
      end
      vectors++;
      assert (Overflow === m_ovf) else begin
         miscompares++; $error("FAIL ovf t=%0t got %b exp %b", $time, Overflow, m_ovf);
      end
      vectors++;
      assert (Busy === m_busy) else begin
         miscompares++; $error("FAIL busy t=%0t got %b exp %b", $time, Busy, m_busy);
      end
      vectors++;
      assert (FinalShown === m_final) else begin
         miscompares++; $error("FAIL final t=%0t got %b exp %b", $time, FinalShown, m_final);
      end
      vectors++;
      assert (Anode === m_anode) else begin
         miscompares++; $error("FAIL anode t=%0t got %b exp %b", $time, Anode, m_anode);
      end
      vectors++;
      assert (Seg === m_seg) else begin
         miscompares++; $error("FAIL seg t=%0t got %b exp %b", $time, Seg, m_seg);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      Reset = 1'b1; Count = 16'd1234; StopCounter = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // Hold 1234 and watch the digits rotate
      Reset = 1'b0;
      for (int i = 0; i < 60; i++) step();
      vectors++;
      assert (BcdOut === 16'h1234) else begin
         miscompares++; $error("FAIL hold1234 got %h exp %h", BcdOut, 16'h1234);
      end

      Count = 16'd65535;
      for (int i = 0; i < 40; i++) step();
      vectors++;
      assert (BcdOut === 16'h9999 && Overflow === 1'b1) else begin
         miscompares++; $error("FAIL sat got %h/%b exp 9999/1", BcdOut, Overflow);
      end
      Count = 16'd7;
      for (int i = 0; i < 40; i++) step();

      // Input changing every cycle
      for (int i = 0; i < 80; i++) begin
         Count = 16'(100 + i);
         step();
      end

      // Reset in the middle of a conversion
      Count = 16'd4321;
      for (int i = 0; i < 40 && m_left != 17; i++) step();
      vectors++;
      assert (m_left == 17) else begin
         miscompares++; $error("FAIL capture_timeout got %0d exp 17", m_left);
      end
      for (int i = 0; i < 8; i++) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int i = 0; i < 40; i++) step();

      // Count up to 42, then freeze with StopCounter
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int i = 0; i < 42; i++) begin
         Count = 16'(i);
         step();
      end
      Count = 16'd42; StopCounter = 1'b1;
      for (int i = 0; i < 60; i++) step();
      vectors++;
      assert (FinalShown === 1'b1 && BcdOut === 16'h0042) else begin
         miscompares++; $error("FAIL final42 got %b/%h exp 1/0042", FinalShown, BcdOut);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: Count = 16'($urandom_range(0, 99));
            1: Count = 16'($urandom_range(0, 9999));
            2: Count = 16'($urandom);
            default: ;
         endcase
         StopCounter = ($urandom_range(0, 15) == 0);
         Reset       = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 16-bit elapsed-seconds count produced by the counter stage.
- Converts the binary count to BCD with a sequential double-dabble engine (one shift per clock).
- Drives a 4-digit, time-multiplexed, active-low seven-segment display.
- Reports when the final value, after the count has stopped, is on the display.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2.
- BLANK_LZ, 1: 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Count  in  16  binary count from the counter stage.
- StopCounter  in  1  high once the prime calculation is finished and the counter is frozen.
- BcdOut  out  16  four BCD digits of the displayed value; [3:0] is the ones digit.
- Overflow  out  1  last converted value was > 9999.
- Busy  out  1  conversion in progress.
- FinalShown  out  1  sticky; final stopped value is converted and displayed.
- Anode  out  4  digit enables, active-low; Anode[0] is the ones digit.
- Seg  out  7  segments, active-low; Seg[0]=a … Seg[6]=g.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. Every register takes its reset value on the first rising edge with Reset=1.
- Reset values:
  - BcdOut=0, Overflow=0, Busy=0, FinalShown=0.
  - Anode=4'b1111, Seg=7'b1111111.
  - Refresh counter=0, DigitSel=0, Valid=0, Last=0.
- Reset mid-conversion: the conversion is aborted with no partial update of BcdOut.
- FSM states:
  - IDLE: capture when (Valid==0 || Count!=Last). On capture, latch Count into the shift register, latch Last<=Count and StopFlag<=StopCounter, clear the BCD scratch register (20 bits, 5 digits), and go to CONVERT. Busy=1 from the next cycle.
  - CONVERT: exactly 16 cycles. Each cycle: add 3 to every scratch digit >= 5, then shift {scratch, bin} left by 1. A 5-bit iteration counter is used.
  - LOAD: 1 cycle.
    - If scratch > 9999 (ten-thousands digit != 0): BcdOut<=16'h9999 and Overflow<=1.
    - Otherwise: BcdOut<=scratch[15:0] and Overflow<=0.
    - Valid<=1 and Busy<=0.
    - If StopFlag=1: FinalShown<=1.
    - Return to IDLE.
- Latency: BcdOut is updated on the 17th rising edge after the capture edge. Busy is high for 17 cycles. Minimum update period is 18 cycles.
- Count changes during CONVERT/LOAD are ignored; the new value is picked up on the next IDLE cycle. Values are never queued.
- FinalShown stays set until Reset. A capture with StopCounter=0 never sets it.
- Multiplexer:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously.
  - On wrap, DigitSel increments mod 4 (order 0,1,2,3,0…).
  - Anode and Seg are registered from the current DigitSel and BcdOut, giving 1-cycle latency. The first cycle after reset is released: Anode=4'b1110, Seg shows the ones digit.
  - Anode has exactly one bit low at a time.
- Segment codes (Seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Leading-zero blanking: when BLANK_LZ=1, digit k>0 is blanked if it and all digits above it are 0. Its Anode bit is still driven low and Seg=1111111.
- Multiplexer timing is independent of the FSM; BcdOut changes take effect at the next Seg register update.

Test Plan:
- Reset check: Reset high 3 cycles -> BcdOut=0, Overflow=0, Busy=0, FinalShown=0, Anode=1111, Seg=1111111. Release Reset -> next cycle Anode=1110, Seg=1000000.
- Basic conversion: Count=1234 held after reset -> Busy high 17 cycles, then BcdOut=16'h1234, Overflow=0. With REFRESH_DIV=4, Seg cycles 1111001/0100100/0110000/0011001 on Anode 0111/1011/1101/1110 respectively, each for 4 cycles.
- Overflow and leading-zero blanking:
  - Count=65535 -> BcdOut=16'h9999, Overflow=1.
  - Then Count=7 -> BcdOut=16'h0007, Overflow=0; digits 1-3 Seg=1111111, digit 0 Seg=1111000.
- Changing input mid-conversion: Count steps 100,101,102… every cycle -> each BcdOut update equals the Count value at its capture edge. Updates are exactly 18 cycles apart and skipped values are never displayed.
- Reset mid-conversion: Count=4321, assert Reset on CONVERT cycle 8 -> BcdOut stays 0, Busy=0. After release, BcdOut=16'h4321 17 cycles after the capture edge.
- Final value and StopCounter: Count counts to 42, then StopCounter=1 and Count is held -> FinalShown rises with the LOAD that sets BcdOut=16'h0042. It stays 1 while Count is held, and a capture taken with StopCounter=0 never sets it.
